// File: rtl/sdram_rd_pkg.sv
// Shared widths and the request tag type used by the SDRAM read responder.
package sdram_rd_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;

  typedef enum logic {
    TAG_MEM  = 1'b0,
    TAG_ZERO = 1'b1
  } rd_tag_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: headData shows the oldest entry whenever empty is low.
// DEPTH must be a power of two so the pointers wrap without extra logic.
module sync_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           pushData,
  input  logic                       pop,
  output logic [WIDTH-1:0]           headData,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             wrEn;
  logic             rdEn;

  assign wrEn     = push & ~full;
  assign rdEn     = pop & ~empty;
  assign empty    = (count == '0);
  assign full     = (count == (PTR_W + 1)'(DEPTH));
  assign headData = mem[rdPtr];

  // NOTE: storage is deliberately not reset; empty/count gate every read, so stale words are never seen.
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrPtr] <= pushData;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + PTR_W'(1);
      if (rdEn) rdPtr <= rdPtr + PTR_W'(1);
      case ({wrEn, rdEn})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_read_responder.sv
// In-order read responder between the LED row fetcher and the SDRAM controller's
// Avalon-MM read port; addresses beyond MEM_WORDS are answered locally with zero.
module sdram_read_responder #(
  parameter int                ADDR_W    = sdram_rd_pkg::ADDR_W,
  parameter int                DATA_W    = sdram_rd_pkg::DATA_W,
  parameter int                MAX_OUT   = 8,
  parameter logic [ADDR_W-1:0] MEM_WORDS = 24'h40_0000
) (
  input  logic                         SDRAM_CLK,
  input  logic                         reset,
  input  logic                         readReq,
  input  logic [ADDR_W-1:0]            address,
  output logic                         addressAck,
  output logic                         readDataValid,
  output logic [DATA_W-1:0]            readData,
  output logic [ADDR_W-1:0]            avm_address,
  output logic                         avm_read,
  input  logic                         avm_waitrequest,
  input  logic                         avm_readdatavalid,
  input  logic [DATA_W-1:0]            avm_readdata,
  output logic [$clog2(MAX_OUT):0]     outstanding,
  output logic                         errUnsolicited
);

  import sdram_rd_pkg::*;

  localparam int CNT_W = $clog2(MAX_OUT) + 1;

  logic              credit;
  logic              inRange;
  logic              memAccept;
  logic              memReturn;
  logic              unsolicited;
  logic              tagEmpty;
  logic              tagFull;
  logic              dataEmpty;
  logic              dataFull;
  logic              tagPop;
  logic              dataPop;
  logic              nextValid;
  logic [DATA_W-1:0] nextData;
  logic [DATA_W-1:0] dataHead;
  logic [CNT_W-1:0]  tagCount;
  logic [CNT_W-1:0]  dataCount;
  logic [CNT_W-1:0]  memTags;
  logic [CNT_W-1:0]  memPending;
  logic [0:0]        tagHeadBits;
  rd_tag_t           tagIn;
  rd_tag_t           tagHead;

  assign credit      = ~tagFull;
  assign inRange     = (address < MEM_WORDS);
  assign avm_address = address;
  assign avm_read    = readReq & credit & inRange;
  assign addressAck  = readReq & credit & (inRange ? ~avm_waitrequest : 1'b1);
  assign memAccept   = addressAck & inRange;
  assign tagIn       = inRange ? TAG_MEM : TAG_ZERO;
  assign tagHead     = rd_tag_t'(tagHeadBits);
  assign outstanding = tagCount;

  // Unmatched mem tags = mem tags still queued minus the words already waiting for them.
  assign memPending  = memTags - dataCount;
  assign memReturn   = avm_readdatavalid & (memPending != '0) & ~dataFull;
  assign unsolicited = avm_readdatavalid & (memPending == '0);

  sync_fifo #(
    .WIDTH (1),
    .DEPTH (MAX_OUT)
  ) tagFifo (
    .clk      (SDRAM_CLK),
    .reset    (reset),
    .push     (addressAck),
    .pushData (tagIn),
    .pop      (tagPop),
    .headData (tagHeadBits),
    .count    (tagCount),
    .empty    (tagEmpty),
    .full     (tagFull)
  );

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (MAX_OUT)
  ) dataFifo (
    .clk      (SDRAM_CLK),
    .reset    (reset),
    .push     (memReturn),
    .pushData (avm_readdata),
    .pop      (dataPop),
    .headData (dataHead),
    .count    (dataCount),
    .empty    (dataEmpty),
    .full     (dataFull)
  );

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    tagPop    = 1'b0;
    dataPop   = 1'b0;
    nextValid = 1'b0;
    nextData  = readData;
    if (!tagEmpty) begin
      if (tagHead == TAG_ZERO) begin
        tagPop    = 1'b1;
        nextValid = 1'b1;
        nextData  = '0;
      end else if (!dataEmpty) begin
        tagPop    = 1'b1;
        dataPop   = 1'b1;
        nextValid = 1'b1;
        nextData  = dataHead;
      end
    end
  end

  always_ff @(posedge SDRAM_CLK or posedge reset) begin
    if (reset) begin
      readDataValid  <= 1'b0;
      readData       <= '0;
      memTags        <= '0;
      errUnsolicited <= 1'b0;
    end else begin
      readDataValid  <= nextValid;
      readData       <= nextData;
      memTags        <= memTags + CNT_W'(memAccept) - CNT_W'(dataPop);
      errUnsolicited <= errUnsolicited | unsolicited;
    end
  end

endmodule

// File: tb/tb_sdram_read_responder.sv
// Self-checking bench for sdram_read_responder: a request-level model predicts acks,
// occupancy and the ordered return stream while a bench-side controller answers reads.
module tb_sdram_read_responder;

  localparam int          MAX_OUT   = 8;
  localparam logic [23:0] MEM_WORDS = 24'h40_0000;

  logic        SDRAM_CLK = 1'b0;
  logic        reset = 1'b1;
  logic        readReq = 1'b0;
  logic [23:0] address = '0;
  logic        addressAck;
  logic        readDataValid;
  logic [15:0] readData;
  logic [23:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic        avm_readdatavalid = 1'b0;
  logic [15:0] avm_readdata = '0;
  logic [3:0]  outstanding;
  logic        errUnsolicited;

  always #5 SDRAM_CLK = ~SDRAM_CLK;

  sdram_read_responder #(
    .ADDR_W    (24),
    .DATA_W    (16),
    .MAX_OUT   (MAX_OUT),
    .MEM_WORDS (MEM_WORDS)
  ) dut (
    .SDRAM_CLK         (SDRAM_CLK),
    .reset             (reset),
    .readReq           (readReq),
    .address           (address),
    .addressAck        (addressAck),
    .readDataValid     (readDataValid),
    .readData          (readData),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdatavalid (avm_readdatavalid),
    .avm_readdata      (avm_readdata),
    .outstanding       (outstanding),
    .errUnsolicited    (errUnsolicited)
  );

  // One entry per accepted request, in accept order; ready is the earliest visible return cycle.
  typedef struct {
    logic [15:0] data;
    bit          isMem;
    bit          known;
    int          ready;
  } exp_t;

  typedef struct {
    logic [15:0] data;
    int          due;
  } ctl_t;

  exp_t        expQ[$];
  ctl_t        ctlQ[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          ackCount = 0;
  int          retCount = 0;
  int          ctlLat = 4;
  bit          hold = 1'b0;
  bit          injectUnsol = 1'b0;
  bit          errModel = 1'b0;
  bit          useAddrData = 1'b1;
  bit          expAck;
  logic [15:0] lastData = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive controller return, check comb outputs, advance model, check registered outputs.
  task automatic cycle();
    bit          ctlValid;
    bit          inRange;
    bit          expRead;
    bit          found;
    logic [15:0] ctlData;
    logic [15:0] rdData;
    int          due;
    ctlValid = 1'b0;
    ctlData  = '0;
    if (injectUnsol) begin
      ctlValid    = 1'b1;
      ctlData     = 16'($urandom);
      injectUnsol = 1'b0;
    end else if (!hold && ctlQ.size() > 0 && ctlQ[0].due <= cyc) begin
      ctlValid = 1'b1;
      ctlData  = ctlQ[0].data;
      void'(ctlQ.pop_front());
    end
    avm_readdatavalid = ctlValid;
    avm_readdata      = ctlData;
    inRange = (address < MEM_WORDS);
    expAck  = readReq && (expQ.size() < MAX_OUT) && (!inRange || !avm_waitrequest);
    expRead = readReq && (expQ.size() < MAX_OUT) && inRange;
    #1;
    check("addressAck", addressAck, expAck);
    check("avm_read", avm_read, expRead);
    check("avm_address", avm_address, address);
    @(posedge SDRAM_CLK);
    if (ctlValid) begin
      found = 1'b0;
      foreach (expQ[i]) begin
        if (!found && expQ[i].isMem && !expQ[i].known) begin
          expQ[i].known = 1'b1;
          expQ[i].data  = ctlData;
          expQ[i].ready = cyc + 2;
          found = 1'b1;
        end
      end
      if (!found) errModel = 1'b1;
    end
    if (expAck) begin
      ackCount++;
      if (inRange) begin
        rdData = useAddrData ? (address[15:0] ^ 16'hA5A5) : 16'($urandom);
        due = cyc + ctlLat;
        if (ctlQ.size() > 0 && ctlQ[$].due >= due) due = ctlQ[$].due + 1;
        ctlQ.push_back('{data: rdData, due: due});
        expQ.push_back('{data: 16'h0, isMem: 1'b1, known: 1'b0, ready: 0});
      end else begin
        expQ.push_back('{data: 16'h0, isMem: 1'b0, known: 1'b1, ready: cyc + 2});
      end
    end
    cyc++;
    #1;
    if (expQ.size() > 0 && expQ[0].known && expQ[0].ready <= cyc) begin
      check("readDataValid", readDataValid, 1);
      check("readData", readData, expQ[0].data);
      lastData = expQ[0].data;
      void'(expQ.pop_front());
      retCount++;
    end else begin
      check("readDataValid", readDataValid, 0);
      check("readData_hold", readData, lastData);
    end
    check("outstanding", outstanding, expQ.size());
    check("errUnsolicited", errUnsolicited, errModel);
  endtask

  task automatic drain();
    int n = 0;
    readReq = 1'b0;
    while ((expQ.size() > 0 || ctlQ.size() > 0) && n < 300) begin
      cycle();
      n++;
    end
    check("drain_left", expQ.size() + ctlQ.size(), 0);
    cycle();
  endtask

  initial begin
    int a0;
    int r0;
    int n;
    int nMem;
    bit tog;

    // Reset state while reset is held.
    repeat (2) @(posedge SDRAM_CLK);
    #1;
    check("rst_valid", readDataValid, 0);
    check("rst_data", readData, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_err", errUnsolicited, 0);
    reset = 1'b0;

    // 1: streaming in-range reads, fixed latency 4, data = addr ^ A5A5.
    a0 = ackCount; r0 = retCount;
    readReq = 1'b1; address = 24'd0;
    repeat (128) begin
      cycle();
      if (expAck) address++;
    end
    check("t1_acks", ackCount - a0, 128);
    drain();
    check("t1_returns", retCount - r0, 128);

    // 2: controller holds its data until the tag FIFO fills.
    useAddrData = 1'b0;
    a0 = ackCount; r0 = retCount;
    hold = 1'b1; readReq = 1'b1; address = 24'h100;
    repeat (12) begin
      cycle();
      if (expAck) address++;
    end
    check("t2_acks_held", ackCount - a0, 8);
    check("t2_full", outstanding, 8);
    hold = 1'b0;
    repeat (12) begin
      cycle();
      if (expAck) address++;
    end
    check("t2_acks_resumed", (ackCount - a0) > 8, 1);
    drain();
    check("t2_returns", retCount - r0, ackCount - a0);

    // 3: straddle the end of memory.
    a0 = ackCount; r0 = retCount; nMem = 0;
    readReq = 1'b1; address = MEM_WORDS - 24'd2;
    n = 0;
    while (ackCount - a0 < 4 && n < 20) begin
      if (address < MEM_WORDS && readReq) nMem++;
      cycle();
      if (expAck) address++;
      n++;
    end
    check("t3_acks", ackCount - a0, 4);
    check("t3_mem_reads", nMem, 2);
    drain();
    check("t3_returns", retCount - r0, 4);
    check("t3_last_zero", lastData, 0);

    // 4: waitrequest toggles every cycle.
    a0 = ackCount; r0 = retCount;
    readReq = 1'b1; address = 24'h2000; tog = 1'b1; n = 0;
    while (ackCount - a0 < 16 && n < 100) begin
      avm_waitrequest = tog;
      tog = ~tog;
      cycle();
      if (expAck) address++;
      n++;
    end
    avm_waitrequest = 1'b0;
    check("t4_acks", ackCount - a0, 16);
    drain();
    check("t4_returns", retCount - r0, 16);

    // 5: readReq drops with 5 in flight, then an unsolicited return.
    a0 = ackCount; r0 = retCount;
    readReq = 1'b1; address = 24'h3000; n = 0;
    while (ackCount - a0 < 5 && n < 20) begin
      cycle();
      if (expAck) address++;
      n++;
    end
    check("t5_inflight", outstanding, 5);
    drain();
    check("t5_returns", retCount - r0, 5);
    r0 = retCount;
    injectUnsol = 1'b1;
    cycle();
    cycle();
    check("t5_err", errUnsolicited, 1);
    check("t5_no_extra", retCount - r0, 0);

    // 6: asynchronous reset mid-burst with 6 outstanding.
    a0 = ackCount;
    hold = 1'b1; readReq = 1'b1; address = 24'h4000; n = 0;
    while (ackCount - a0 < 6 && n < 20) begin
      cycle();
      if (expAck) address++;
      n++;
    end
    readReq = 1'b0;
    check("t6_pre_outstanding", outstanding, 6);
    reset = 1'b1;
    #1;
    check("t6_async_valid", readDataValid, 0);
    check("t6_async_outstanding", outstanding, 0);
    check("t6_async_err", errUnsolicited, 0);
    expQ.delete(); ctlQ.delete();
    errModel = 1'b0; lastData = '0; hold = 1'b0;
    avm_readdatavalid = 1'b0;
    @(posedge SDRAM_CLK);
    cyc++;
    #1;
    reset = 1'b0;
    a0 = ackCount; r0 = retCount;
    readReq = 1'b1; address = 24'h5000;
    repeat (20) begin
      cycle();
      if (expAck) address++;
    end
    drain();
    check("t6_fresh_returns", retCount - r0, ackCount - a0);

    // 7: random mix of requests, stalls, latencies and out-of-range addresses.
    a0 = ackCount; r0 = retCount;
    address = 24'($urandom_range(0, 1000));
    repeat (400) begin
      readReq         = ($urandom_range(0, 3) != 0);
      avm_waitrequest = ($urandom_range(0, 2) == 0);
      hold            = ($urandom_range(0, 4) == 0);
      ctlLat          = $urandom_range(1, 6);
      cycle();
      if (expAck) begin
        if ($urandom_range(0, 1) == 0) address = 24'($urandom_range(0, 32'h3F_FFFF));
        else address = MEM_WORDS + 24'($urandom_range(0, 32'h3F_FFFF));
      end
    end
    hold = 1'b0; avm_waitrequest = 1'b0;
    drain();
    check("t7_returns", retCount - r0, ackCount - a0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
